// File: rtl/sdram_dp_pkg.sv
// Shared constants, state encoding and field normalisers for the SDRAM data path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sdram_dp_pkg;

  localparam int DATA_SIZE = 32;
  localparam int BL_WIDTH  = 4;
  localparam int BURST_MAX = 8;
  localparam int CAS_MAX   = 3;

  // CAS latency codes actually used after normalisation
  localparam logic [1:0] CAS_CL2 = 2'd2;
  localparam logic [1:0] CAS_CL3 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RD_BURST = 2'd3
  } state_e;

  // Zero-length bursts become single words; oversize bursts clamp to the maximum.
  function automatic logic [BL_WIDTH-1:0] norm_bl(input logic [BL_WIDTH-1:0] bl);
    if (bl == '0) begin
      return BL_WIDTH'(1);
    end else if (bl > BL_WIDTH'(BURST_MAX)) begin
      return BL_WIDTH'(BURST_MAX);
    end else begin
      return bl;
    end
  endfunction

  // CAS codes below 2 are not supported by the device; treat them as CL2.
  function automatic logic [1:0] norm_cl(input logic [1:0] code);
    if (code < CAS_CL2) begin
      return CAS_CL2;
    end else if (code > 2'(CAS_MAX)) begin
      return 2'(CAS_MAX);
    end else begin
      return code;
    end
  endfunction

endpackage

// File: rtl/sdram_dp_rd_capture.sv
// Read capture: delays the per-word "data expected" tag by CL and samples dq_in.
// Latency: rd_valid/rd_data one cycle after the word is on the pins (CL+1 after tag).
// Backpressure: none; the host must accept every rd_valid word.
module sdram_rd_capture
  import sdram_dp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tag_i,
  input  logic [1:0]           cl_i,
  input  logic [DATA_SIZE-1:0] dq_i,
  output logic [DATA_SIZE-1:0] rd_data_o,
  output logic                 rd_valid_o
);

  // Stages: tag input, CAS_MAX delay flops, valid/capture register (CAS_MAX+2 total).
  // tag_sr_q[i] is the tag delayed by i+1 cycles.
  logic [CAS_MAX-1:0]   tag_sr_q, tag_sr_d;
  logic                 data_on_pins;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  // Shift the tag and pick the tap that lines up with data on the pins.
  always_comb begin
    tag_sr_d     = {tag_sr_q[CAS_MAX-2:0], tag_i};
    data_on_pins = (cl_i == CAS_CL3) ? tag_sr_q[CAS_MAX-1] : tag_sr_q[1];
    rd_valid_d   = data_on_pins;
    rd_data_d    = data_on_pins ? dq_i : rd_data_q;
  end

  // Capture registers; reset discards anything still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_sr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      tag_sr_q   <= tag_sr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/sdram_dp.sv
// SDRAM data path: write-data/oe sequencing and CL-aligned read capture.
// Latency: write word on pins 1 cycle after wr_ack; read word returned CL+2 cycles after cmd_read.
// Backpressure: commands while busy are dropped and flagged on cmd_err the next cycle.
module sdram_dp
  import sdram_dp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_write,
  input  logic                 cmd_read,
  input  logic [BL_WIDTH-1:0]  burst_len,
  input  logic [1:0]           cas_lat,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 wr_ack,
  input  logic [DATA_SIZE-1:0] dq_in,
  output logic [DATA_SIZE-1:0] sdram_out,
  output logic                 oe,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 cmd_err
);

  state_e               state_q, state_d;
  logic [BL_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BL_WIDTH-1:0]  bl_rd_q, bl_rd_d;
  logic [1:0]           cl_q, cl_d;
  logic [BL_WIDTH-1:0]  tag_cnt_q, tag_cnt_d;
  logic [DATA_SIZE-1:0] sdram_out_q;
  logic                 oe_q;
  logic                 cmd_err_q, cmd_err_d;

  logic [BL_WIDTH-1:0]  bl_n;
  logic [1:0]           cl_n;
  logic                 accept, wr_go, rd_go, rd_tag;

  // The trailing rd_valid cycle happens after the FSM is back in IDLE, so it counts as busy.
  assign busy   = (state_q != S_IDLE) || rd_valid;
  assign accept = !busy && !reset;
  assign bl_n   = norm_bl(burst_len);
  assign cl_n   = norm_cl(cas_lat);
  assign wr_go  = accept && cmd_write;
  assign rd_go  = accept && cmd_read && !cmd_write;
  assign rd_tag = (tag_cnt_q != '0);

  // Next-state, burst/latency counter and write acknowledge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bl_rd_d = bl_rd_q;
    cl_d    = cl_q;
    wr_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_go) begin
          wr_ack  = 1'b1;
          state_d = S_WRITE;
          cnt_d   = bl_n - BL_WIDTH'(1);
        end else if (rd_go) begin
          state_d = S_RD_WAIT;
          cnt_d   = BL_WIDTH'(cl_n) - BL_WIDTH'(1);
          bl_rd_d = bl_n;
          cl_d    = cl_n;
        end
      end
      // cnt==0 is the turnaround cycle: last word still on the pins, no more acks.
      S_WRITE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          wr_ack = 1'b1;
          cnt_d  = cnt_q - BL_WIDTH'(1);
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RD_BURST;
          cnt_d   = bl_rd_q - BL_WIDTH'(1);
        end else begin
          cnt_d = cnt_q - BL_WIDTH'(1);
        end
      end
      S_RD_BURST: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - BL_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One tag per requested word, starting the cycle the READ command is on the pins.
  always_comb begin
    tag_cnt_d = tag_cnt_q;
    if (rd_go) begin
      tag_cnt_d = bl_n;
    end else if (rd_tag) begin
      tag_cnt_d = tag_cnt_q - BL_WIDTH'(1);
    end
  end

  // Rejected commands: anything while busy, or a read colliding with a write.
  always_comb begin
    cmd_err_d = ((cmd_write || cmd_read) && busy) || (cmd_write && cmd_read);
  end

  // State and output registers; reset drops oe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bl_rd_q     <= '0;
      cl_q        <= CAS_CL2;
      tag_cnt_q   <= '0;
      sdram_out_q <= '0;
      oe_q        <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bl_rd_q   <= bl_rd_d;
      cl_q      <= cl_d;
      tag_cnt_q <= tag_cnt_d;
      oe_q      <= wr_ack;
      cmd_err_q <= cmd_err_d;
      if (wr_ack) begin
        sdram_out_q <= wr_data;
      end
    end
  end

  assign sdram_out = sdram_out_q;
  assign oe        = oe_q;
  assign cmd_err   = cmd_err_q;

  sdram_rd_capture u_rd_capture (
    .clk        (clk),
    .reset      (reset),
    .tag_i      (rd_tag),
    .cl_i       (cl_q),
    .dq_i       (dq_in),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );

endmodule
